// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative shift-add multiply and restoring divide
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int BP_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic [BP_W-1:0]  bit_position,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_0,
  output logic [WIDTH-1:0] result_1,
  output logic [7:0]       flag_reg
);

  // EXEC is the one-cycle compute/writeback step every operation passes through
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_MUL  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_NOT  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_XOR  = 5'b00111;
  localparam logic [4:0] OP_INC  = 5'b01000;
  localparam logic [4:0] OP_CMP  = 5'b01001;
  localparam logic [4:0] OP_RR   = 5'b01010;
  localparam logic [4:0] OP_RL   = 5'b01011;
  localparam logic [4:0] OP_SETB = 5'b01100;
  localparam logic [4:0] OP_CLRB = 5'b01101;
  localparam logic [4:0] OP_SETF = 5'b01110;
  localparam logic [4:0] OP_SWAP = 5'b01111;

  logic [1:0]       state;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [BP_W-1:0]  bp_q;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] eng_lo;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             is_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;

  logic [WIDTH-1:0] r0_n;
  logic [WIDTH-1:0] r1_n;
  logic [7:0]       flag_n;
  logic             c_f, v_f, gt_f, eq_f, lt_f, dz_f;
  logic             legal;
  logic             setf;
  logic [2:0]       setf_idx;
  logic [WIDTH-1:0] bit_mask;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign is_iter   = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operand_2 != '0));

  // eng_hi holds product-high / partial remainder, eng_lo multiplier / dividend-quotient
  assign mul_sum   = {1'b0, eng_hi} + (eng_lo[0] ? {1'b0, b_q} : '0);
  assign div_trial = {eng_hi, eng_lo[WIDTH-1]} - {1'b0, b_q};

  assign setf_idx  = 3'(bp_q);
  assign bit_mask  = WIDTH'(1) << bp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bp_q     <= '0;
      eng_hi   <= '0;
      eng_lo   <= '0;
      cnt      <= '0;
      result_0 <= '0;
      result_1 <= '0;
      flag_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= opcode;
            a_q    <= operand_1;
            b_q    <= operand_2;
            bp_q   <= bit_position;
            eng_hi <= '0;
            eng_lo <= operand_1;
            cnt    <= '0;
            state  <= is_iter ? S_BUSY : S_EXEC;
          end
        end
        S_BUSY: begin
          if (op_q == OP_MUL) begin
            eng_hi <= mul_sum[WIDTH:1];
            eng_lo <= {mul_sum[0], eng_lo[WIDTH-1:1]};
          end else if (div_trial[WIDTH]) begin
            eng_hi <= {eng_hi[WIDTH-2:0], eng_lo[WIDTH-1]};
            eng_lo <= {eng_lo[WIDTH-2:0], 1'b0};
          end else begin
            eng_hi <= div_trial[WIDTH-1:0];
            eng_lo <= {eng_lo[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_EXEC;
        end
        S_EXEC: begin
          result_0 <= r0_n;
          result_1 <= r1_n;
          flag_reg <= flag_n;
          state    <= S_DONE;
        end
        default: begin
          if (out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    r0_n  = '0;
    r1_n  = '0;
    c_f   = 1'b0;
    v_f   = 1'b0;
    gt_f  = 1'b0;
    eq_f  = 1'b0;
    lt_f  = 1'b0;
    dz_f  = 1'b0;
    legal = 1'b1;
    setf  = 1'b0;
    case (op_q)
      OP_ADD: begin
        {c_f, r0_n} = {1'b0, a_q} + {1'b0, b_q};
        v_f = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r0_n[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        r0_n = eng_lo;
        r1_n = eng_hi;
      end
      OP_SUB: begin
        r0_n = a_q - b_q;
        c_f  = (a_q < b_q);
        v_f  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (r0_n[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_DIV: begin
        if (b_q == '0) begin
          r0_n = '1;
          r1_n = a_q;
          dz_f = 1'b1;
        end else begin
          r0_n = eng_lo;
          r1_n = eng_hi;
        end
      end
      OP_NOT:  r0_n = ~a_q;
      OP_AND:  r0_n = a_q & b_q;
      OP_OR:   r0_n = a_q | b_q;
      OP_XOR:  r0_n = a_q ^ b_q;
      OP_INC:  {c_f, r0_n} = {1'b0, a_q} + (WIDTH+1)'(1);
      OP_CMP: begin
        gt_f = (a_q > b_q);
        eq_f = (a_q == b_q);
        lt_f = (a_q < b_q);
      end
      OP_RR: begin
        r0_n = {a_q[0], a_q[WIDTH-1:1]};
        c_f  = a_q[0];
      end
      OP_RL: begin
        r0_n = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        c_f  = a_q[WIDTH-1];
      end
      OP_SETB: r0_n = a_q | bit_mask;
      OP_CLRB: r0_n = a_q & ~bit_mask;
      OP_SETF: setf = 1'b1;
      OP_SWAP: r0_n = {a_q[WIDTH/2-1:0], a_q[WIDTH-1:WIDTH/2]};
      default: legal = 1'b0;
    endcase

    if (!legal)
      flag_n = flag_reg;
    else if (setf)
      flag_n = flag_reg | (8'd1 << setf_idx);
    else
      flag_n = {(r0_n == '0), r0_n[WIDTH-1], dz_f, lt_f, eq_f, gt_f, v_f, c_f};
  end

endmodule
